// File: rtl/serial_mod_checker.sv
// serial_mod_checker: bit-serial running residue mod DIVISOR with a multiple-of flag
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   inp       : serial data bit, qualified by in_valid
//   in_valid  : one bit accepted per cycle while high
//   start     : with in_valid, inp is the first bit of a new number
//   lsb_first : bit order of the frame, latched on an accepted start
//   out       : residue after the last accepted bit is zero
//   residue   : running value mod DIVISOR
//   bit_count : saturating number of bits accepted in the current frame
//   out_valid : outputs were updated by an accepted bit at this edge
module serial_mod_checker #(
    parameter int DIVISOR = 5,
    parameter int RW = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp,
    input  logic             in_valid,
    input  logic             start,
    input  logic             lsb_first,
    output logic             out,
    output logic [RW-1:0]    residue,
    output logic [CNT_W-1:0] bit_count,
    output logic             out_valid
);
    localparam logic [RW:0] D = (RW+1)'(DIVISOR);
    logic [RW-1:0] r_q, r_d, p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic m_q, m_d, out_q, out_d, ov_q, ov_d;
    logic [RW:0] msb_sum, lsb_sum;
    // Both sums stay below 2*DIVISOR, so one conditional subtract fully reduces them.
    function automatic logic [RW-1:0] red(input logic [RW:0] s);
        logic [RW:0] t;
        t = s >= D ? s - D : s;
        return t[RW-1:0];
    endfunction
    always_comb begin
        msb_sum = {r_q, 1'b0} + (RW+1)'(inp);
        lsb_sum = {1'b0, r_q} + (inp ? {1'b0, p_q} : '0);
        r_d = start ? RW'(inp) : red(m_q ? lsb_sum : msb_sum);
        // p holds the weight of the next LSB-first bit; a start bit has weight 1, so the next is 2.
        p_d = start ? red((RW+1)'(2)) : m_q ? red({p_q, 1'b0}) : p_q;
        m_d = start ? lsb_first : m_q;
        cnt_d = start ? CNT_W'(1) : &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
        out_d = r_d == '0;
        ov_d = in_valid;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
            p_q <= RW'(1);
            m_q <= 1'b0;
            cnt_q <= '0;
            out_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            ov_q <= ov_d;
            if (in_valid) begin
                r_q <= r_d;
                p_q <= p_d;
                m_q <= m_d;
                cnt_q <= cnt_d;
                out_q <= out_d;
            end
        end
    end
    assign out = out_q;
    assign residue = r_q;
    assign bit_count = cnt_q;
    assign out_valid = ov_q;
endmodule

// File: tb/tb_serial_mod_checker.sv
// tb_serial_mod_checker: scoreboard bench driving divisor-5, divisor-7 and 4-bit-counter instances in lockstep
module tb_serial_mod_checker;
    logic clk = 1'b0;
    logic rst, inp, in_valid, start, lsb_first;
    logic o5, v5, o7, v7, o_s, v_s;
    logic [2:0] r5, r7, r_s;
    logic [15:0] c5, c7;
    logic [3:0] c_s;
    int checks = 0, errors = 0;
    typedef struct {int r5; int r7; int n; bit o5; bit o7;} exp_t;
    exp_t sb[$];
    exp_t cur;
    longint unsigned fv = 0;
    int fn = 0, cnt = 0;
    bit mode = 0;
    int msb_r[4] = '{1, 2, 0, 0};
    int msb_o[4] = '{0, 0, 1, 1};
    int msb_b[4] = '{1, 0, 1, 0};
    int lsb_r[4] = '{0, 2, 1, 4};
    int lsb_o[4] = '{1, 0, 0, 0};
    int lsb_b[4] = '{0, 1, 1, 1};

    always #5 clk = ~clk;

    serial_mod_checker #(.DIVISOR(5), .RW(3), .CNT_W(16)) u5 (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .start(start), .lsb_first(lsb_first),
        .out(o5), .residue(r5), .bit_count(c5), .out_valid(v5));
    serial_mod_checker #(.DIVISOR(7), .RW(3), .CNT_W(16)) u7 (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .start(start), .lsb_first(lsb_first),
        .out(o7), .residue(r7), .bit_count(c7), .out_valid(v7));
    serial_mod_checker #(.DIVISOR(7), .RW(3), .CNT_W(4)) us (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .start(start), .lsb_first(lsb_first),
        .out(o_s), .residue(r_s), .bit_count(c_s), .out_valid(v_s));

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tbl(input string tag, input int r, input int o, input int n);
        chk({tag, "_res"}, 32'(r5), r);
        chk({tag, "_out"}, 32'(o5), o);
        chk({tag, "_cnt"}, 32'(c5), n);
    endtask

    task automatic step(input bit v, input bit s, input bit b, input bit l, input bit rs);
        exp_t e;
        rst = rs; in_valid = v; start = s; inp = b; lsb_first = l;
        if (rs) begin
            mode = 0; fv = 0; fn = 0; cnt = 0;
        end else if (v) begin
            if (s) begin
                mode = l; fv = 0; fn = 0; cnt = 0;
            end
            fv = mode ? fv | (64'(b) << fn) : (fv << 1) | 64'(b);
            fn++;
            cnt++;
            e.r5 = int'(fv % 5);
            e.r7 = int'(fv % 7);
            e.n = cnt;
            e.o5 = e.r5 == 0;
            e.o7 = e.r7 == 0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("ov5", 32'(v5), int'(v && !rs));
        chk("ov7", 32'(v7), int'(v && !rs));
        chk("ov_sat", 32'(v_s), int'(v && !rs));
        if (rs) cur = '{0, 0, 0, 0, 0};
        else if (v5 && sb.size() > 0) cur = sb.pop_front();
        chk("res5", 32'(r5), cur.r5);
        chk("out5", 32'(o5), int'(cur.o5));
        chk("cnt5", 32'(c5), cur.n > 65535 ? 65535 : cur.n);
        chk("res7", 32'(r7), cur.r7);
        chk("out7", 32'(o7), int'(cur.o7));
        chk("cnt7", 32'(c7), cur.n > 65535 ? 65535 : cur.n);
        chk("res_sat", 32'(r_s), cur.r7);
        chk("out_sat", 32'(o_s), int'(cur.o7));
        chk("cnt_sat", 32'(c_s), cur.n > 15 ? 15 : cur.n);
    endtask

    initial begin
        cur = '{0, 0, 0, 0, 0};
        step(0, 0, 0, 0, 1);
        step(1, 1, 1, 1, 1);
        tbl("reset", 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, i == 0, msb_b[i][0], 0, 0);
            tbl("msb", msb_r[i], msb_o[i], i + 1);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, i == 0, lsb_b[i][0], 1, 0);
            tbl("lsb", lsb_r[i], lsb_o[i], i + 1);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (3) begin
                step(0, 1, 1'($urandom % 2), 1'($urandom % 2), 0);
                tbl("gap_hold", msb_r[i-1], msb_o[i-1], i);
            end
            step(1, i == 0, msb_b[i][0], 0, 0);
            tbl("gap", msb_r[i], msb_o[i], i + 1);
        end
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        tbl("pre_restart", 3, 0, 2);
        step(1, 1, 1, 0, 0);
        tbl("restart", 1, 0, 1);
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 0, 1);
        tbl("rst_drop", 0, 0, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        step(1, 0, 0, 1, 0);
        tbl("post_rst_msb", 1, 0, 3);
        for (int i = 0; i < 20; i++) step(1, i == 0, 1'($urandom % 2), 0, 0);
        chk("sat_final", 32'(c_s), 15);
        chk("sat_wide", 32'(c7), 20);
        for (int f = 0; f < 1000; f++) begin
            bit md;
            int len;
            md = 1'($urandom % 2);
            len = int'($urandom_range(1, 40));
            for (int i = 0; i < len; i++) begin
                while ($urandom % 4 == 0) step(0, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 0);
                step(1, i == 0, 1'($urandom % 2), i == 0 ? md : 1'($urandom % 2), 0);
            end
        end
        chk("sb_drain", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_mod_checker.md
# serial_mod_checker

Parametrised bit-serial divisibility checker. It accepts one bit per cycle of an unbounded binary number and keeps that number's running residue modulo DIVISOR. It flags when the number received so far is an exact multiple of DIVISOR. It generalises the fixed divide-by-5 MSB-first detector: any divisor, selectable MSB-first or LSB-first bit order, explicit frame start, a valid qualifier, and a bit counter.

## Interface
Parameters:
- DIVISOR, 5: modulus, legal range 2..255.
- RW, 3: residue width; must satisfy 2^RW >= DIVISOR.
- CNT_W, 16: bit-counter width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- inp  in  1  serial data bit; sampled only when in_valid=1.
- in_valid  in  1  qualifies inp; one bit accepted per cycle with in_valid=1.
- start  in  1  with in_valid=1, marks inp as the first bit of a new number.
- lsb_first  in  1  bit order for the frame: 0 = MSB first, 1 = LSB first. Sampled only on an accepted start bit.
- out  out  1  registered; 1 when the residue after the last accepted bit is 0.
- residue  out  RW  registered running value mod DIVISOR.
- bit_count  out  CNT_W  number of bits accepted in the current frame; saturating.
- out_valid  out  1  one-cycle pulse; out, residue and bit_count were updated by an accepted bit at this edge.

## Operation
- Internal state:
  - residue r
  - power register p (2^k mod DIVISOR, used in LSB mode only)
  - mode register m
  - bit_count
  - registered outputs
- Accept condition: in_valid=1 and rst=0. Without an accept, all state holds and out_valid=0.
- start=1 with in_valid=0 is ignored.
- Accepted start bit:
  - m <= lsb_first
  - r <= inp (prior residue treated as 0)
  - p <= 2 mod DIVISOR
  - bit_count <= 1
- Accepted non-start bit, MSB mode (m=0): r <= (2r + inp) mod DIVISOR; p unused.
- Accepted non-start bit, LSB mode (m=1):
  - r <= (r + inp·p) mod DIVISOR
  - p <= (2p) mod DIVISOR
  - The first bit of a frame uses weight 1.
- Arithmetic:
  - Both intermediate sums are < 2·DIVISOR and are computed at RW+1 bits.
  - Reduction is a single conditional subtract of DIVISOR. No divider or modulo operator.
- bit_count increments per accepted non-start bit and saturates at 2^CNT_W−1. Residue tracking continues past saturation.
- out <= (next r == 0), updated on the same edge as r.
- lsb_first changes mid-frame are ignored until the next accepted start.
- Bits accepted after reset before any start continue from r=0, p=1, m=0 (MSB mode). This is equivalent to an implicit frame start.

## Timing
- Latency is 1 cycle: the bit accepted at edge n is reflected in out, residue, bit_count and out_valid after edge n.
- Throughput is 1 bit/cycle. There is no backpressure.
- Reset values: r=0, residue=0, out=0, out_valid=0, bit_count=0, p=1, m=0.
- rst has priority over in_valid and start. A bit presented in a reset cycle is discarded.
- Reset mid-frame: outputs take reset values after that edge. The next accepted bit continues from r=0 in MSB mode.
- start in consecutive cycles: each accepted start begins a new 1-bit frame.

## Test plan
- MSB mode, DIVISOR=5, bits 1(start),0,1,0 (1010b = 10):
  - residue 1,2,0,0
  - out 0,0,1,1
  - bit_count 1..4
  - out_valid high each cycle
- LSB mode, DIVISOR=5, lsb_first=1, bits 0(start),1,1,1 (values 0,2,6,14):
  - residue 0,2,1,4
  - out 1,0,0,0
- Gaps: repeat the MSB case with 3 idle cycles (in_valid=0) between bits, including start=1 while idle.
  - Values identical to the gap-free run.
  - residue, out and bit_count hold during gaps; out_valid=0 during gaps.
- Restart and reset:
  - Mid-frame start with inp=1 (residue 3 beforehand) -> residue 1, bit_count 1, out 0.
  - rst with in_valid=1 -> next cycle residue 0, out 0, bit_count 0, out_valid 0; the bit is dropped.
- Randomised, DIVISOR=7, RW=3, both modes: 1000 frames of 1–40 bits with random in_valid gaps. Per accepted bit, residue must equal a reference-model value mod 7.
- Saturation, CNT_W=4: 20 accepted bits -> bit_count stays at 15 from the 15th bit on, and residue remains correct.
